imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: instruction memory capacity in 32-bit words (power of two, at most 65535).
REQ-002 Parameter BASE_ADDR, default 32'h0: byte address of word 0; matches the core's initial PC.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 s_valid  in  1  load-stream byte valid.
REQ-006 s_data  in  8  load-stream byte.
REQ-007 s_ready  out  1  loader accepts a byte this cycle.
REQ-008 instr_addr  in  32  fetch byte address from the core.
REQ-009 instr_out  out  32  instruction word to the core's instruction input.
REQ-010 core_reset  out  1  active-high reset to the core; held while not running.
REQ-011 load_done  out  1  program loaded and core released.
REQ-012 load_error  out  1  invalid length header; sticky.
REQ-013 words_loaded  out  16  count of words written so far.

Function
REQ-014 A byte is accepted on a rising clk edge only when s_valid and s_ready are both 1; s_valid while s_ready is 0 is ignored.
REQ-015 FSM states are LEN_LO, LEN_HI, DATA, RUN and ERROR; s_ready is 1 in LEN_LO, LEN_HI and DATA, and 0 in RUN and ERROR.
REQ-016 LEN_LO: an accepted byte becomes length[7:0], then the FSM moves to LEN_HI.
REQ-017 LEN_HI: an accepted byte becomes length[15:8]; next state is DATA if 1 <= length <= DEPTH_WORDS, otherwise ERROR.
REQ-018 DATA: a 2-bit byte counter assembles words little-endian (first byte is bits [7:0]).
REQ-019 On the 4th byte, mem[word_ptr] is written with {b3,b2,b1,b0}, word_ptr and words_loaded increment, and the byte counter wraps to 0.
REQ-020 When the written word is word length-1, the FSM moves to RUN on that same edge.
REQ-021 core_reset is a registered 1 in every state except RUN, so it falls on the edge that enters RUN; load_done rises on that same edge.
REQ-022 RUN and ERROR are terminal until reset_n is asserted; in ERROR, core_reset stays 1 and load_error is 1.
REQ-023 Read index = (instr_addr - BASE_ADDR) >> 2, with combinational (zero-cycle) read.
REQ-024 instr_out is 32'h0 (NOP) when any of the following holds:
- instr_addr[1:0] != 0;
- instr_addr < BASE_ADDR;
- index >= the latched length;
- state != RUN.
REQ-025 A write takes effect for reads from the cycle after the write edge.
REQ-026 Address subtraction is 32-bit modulo; an address below BASE_ADDR is detected by comparison before the subtraction, not by wrap.

Reset
REQ-027 reset_n low immediately forces the following:
- state LEN_LO;
- byte counter, word_ptr, length and words_loaded to 0;
- core_reset 1, load_done 0, load_error 0;
- s_ready 0 while reset_n is low.
REQ-028 Asserting reset_n mid-load discards the partial load; memory contents are not cleared but are masked by length = 0 per REQ-024.
REQ-029 After reset_n deasserts, s_ready is 1 starting from the first clk edge.

Structure
REQ-030 A shared package mips_pkg holds the following:
- the loader state enum;
- the MIPS opcode and funct enums;
- the ALU operation enum.
REQ-031 The storage array is a sub-module imem_ram (DEPTH_WORDS x 32, synchronous write, asynchronous read) with no reset on its contents.
REQ-032 The FSM, byte assembly and read masking reside in imem_loader.

Verification
REQ-033 Directed scenarios:
- Basic load: stream 02 00 78 56 34 12 EF BE AD DE -> mem[0]=32'h12345678 and mem[1]=32'hDEADBEEF. core_reset falls on the edge accepting DE. words_loaded=2. instr_addr 0x4 gives 32'hDEADBEEF; instr_addr 0x8 gives 0.
- Zero length: header 00 00 -> load_error=1 and s_ready=0; core_reset stays 1; later bytes are ignored.
- Oversize length: header encoding DEPTH_WORDS+1 -> ERROR, as in the zero-length case.
- Gaps: the basic-load stream with s_valid deasserted at random cycles -> identical memory contents and words_loaded. s_valid pulses in RUN change nothing.
- Reset mid-load: reset_n pulse after 5 accepted bytes -> LEN_LO, words_loaded=0, core_reset=1, instr_out=0. Reloading 01 00 09 00 1D 24 then gives instr_out=32'h241D0009 at instr_addr 0x0.
- Masking: in RUN, instr_addr 0x2 -> 0. With BASE_ADDR=32'h400000, instr_addr 32'h3FFFFC -> 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: loader FSM states, instruction opcode/funct encodings, ALU operations.
// Pure type/constant package; no logic, no latency, no flow control.
package mips_pkg;

    typedef enum logic [2:0] {
        LEN_LO = 3'd0,
        LEN_HI = 3'd1,
        DATA   = 3'd2,
        RUN    = 3'd3,
        ERROR  = 3'd4
    } ldr_state_e;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDI  = 6'h08,
        OP_ADDIU = 6'h09,
        OP_SLTI  = 6'h0A,
        OP_ANDI  = 6'h0C,
        OP_ORI   = 6'h0D,
        OP_LUI   = 6'h0F,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_e;

    typedef enum logic [5:0] {
        FN_SLL  = 6'h00,
        FN_SRL  = 6'h02,
        FN_JR   = 6'h08,
        FN_ADD  = 6'h20,
        FN_ADDU = 6'h21,
        FN_SUB  = 6'h22,
        FN_SUBU = 6'h23,
        FN_AND  = 6'h24,
        FN_OR   = 6'h25,
        FN_XOR  = 6'h26,
        FN_NOR  = 6'h27,
        FN_SLT  = 6'h2A
    } funct_e;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_NOR = 4'd5,
        ALU_SLT = 4'd6,
        ALU_SLL = 4'd7,
        ALU_SRL = 4'd8,
        ALU_LUI = 4'd9
    } alu_op_e;

endpackage

// File: rtl/imem_ram.sv
// Instruction storage: DEPTH_WORDS x 32, synchronous write, asynchronous read, contents never reset.
// Write visible to reads from the cycle after the write edge; always accepts writes.
module imem_ram #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = 10
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader into instruction memory; holds the core in reset until the image is in.
// One byte per cycle when s_ready; zero-cycle masked fetch read; s_ready drops for good in RUN/ERROR.
module imem_loader
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    input  logic [31:0] instr_addr,
    output logic [31:0] instr_out,
    output logic        core_reset,
    output logic        load_done,
    output logic        load_error,
    output logic [15:0] words_loaded
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    ldr_state_e  state_q, state_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [23:0] wbuf_q, wbuf_d;
    logic [15:0] len_q, len_d;
    logic [15:0] ptr_q, ptr_d;
    logic        rdy_q, core_rst_q, done_q, err_q;

    logic        accept;
    logic [15:0] hdr_len;
    logic        hdr_ok;
    logic        we;
    logic [31:0] wdata;

    assign accept  = s_valid & rdy_q;
    assign hdr_len = {s_data, len_q[7:0]};
    assign hdr_ok  = (hdr_len != 16'd0) && ({16'h0, hdr_len} <= DEPTH_WORDS);
    // b0..b2 are shifted in from the top, so the buffer ends up {b2,b1,b0}.
    assign wdata   = {s_data, wbuf_q};

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        wbuf_d  = wbuf_q;
        len_d   = len_q;
        ptr_d   = ptr_q;
        we      = 1'b0;
        case (state_q)
            LEN_LO: begin
                if (accept) begin
                    len_d   = {8'h00, s_data};
                    state_d = LEN_HI;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    len_d   = hdr_len;
                    state_d = hdr_ok ? DATA : ERROR;
                end
            end
            DATA: begin
                if (accept) begin
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        we    = 1'b1;
                        ptr_d = ptr_q + 16'd1;
                        if (ptr_q == len_q - 16'd1) begin
                            state_d = RUN;
                        end
                    end else begin
                        wbuf_d = {s_data, wbuf_q[23:8]};
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= LEN_LO;
            bcnt_q     <= 2'd0;
            wbuf_q     <= 24'h0;
            len_q      <= 16'h0;
            ptr_q      <= 16'h0;
            rdy_q      <= 1'b0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bcnt_q     <= bcnt_d;
            wbuf_q     <= wbuf_d;
            len_q      <= len_d;
            ptr_q      <= ptr_d;
            rdy_q      <= (state_d == LEN_LO) || (state_d == LEN_HI) || (state_d == DATA);
            core_rst_q <= (state_d != RUN);
            done_q     <= (state_d == RUN);
            err_q      <= (state_d == ERROR);
        end
    end

    assign s_ready      = rdy_q;
    assign core_reset   = core_rst_q;
    assign load_done    = done_q;
    assign load_error   = err_q;
    assign words_loaded = ptr_q;

    // Below-base is caught by compare, so the modulo subtraction never aliases into the image.
    logic        addr_below;
    logic [31:0] rd_idx;
    logic        rd_ok;
    logic [31:0] rdata;

    assign addr_below = instr_addr < BASE_ADDR;
    assign rd_idx     = (instr_addr - BASE_ADDR) >> 2;
    assign rd_ok      = (instr_addr[1:0] == 2'b00) && !addr_below
                        && (rd_idx < {16'h0, len_q}) && (state_q == RUN);
    assign instr_out  = rd_ok ? rdata : 32'h0;

    imem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (ptr_q[AW-1:0]),
        .wdata_i (wdata),
        .raddr_i (rd_idx[AW-1:0]),
        .rdata_o (rdata)
    );

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: two instances (base 0 and base 0x400000) share one load stream.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        s_valid;
    logic [7:0]  s_data;
    logic [31:0] instr_addr, instr_addr2;

    logic        s_ready, core_reset, load_done, load_error;
    logic [31:0] instr_out;
    logic [15:0] words_loaded;
    logic        s_ready2, core_reset2, load_done2, load_error2;
    logic [31:0] instr_out2;
    logic [15:0] words_loaded2;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    imem_loader #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0)) u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .instr_addr   (instr_addr),
        .instr_out    (instr_out),
        .core_reset   (core_reset),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    imem_loader #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0040_0000)) u_dut_hi (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready2),
        .instr_addr   (instr_addr2),
        .instr_out    (instr_out2),
        .core_reset   (core_reset2),
        .load_done    (load_done2),
        .load_error   (load_error2),
        .words_loaded (words_loaded2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Drive one byte at a negedge; optional random idle cycles first; waits (bounded) for s_ready.
    task automatic send(input logic [7:0] b, input int unsigned maxgap);
        int w;
        repeat ($urandom_range(maxgap, 0)) @(negedge clk);
        w = 0;
        while (!s_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("send_ready", {31'h0, s_ready}, 32'h1);
        s_valid = 1'b1;
        s_data  = b;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst_s_ready", {31'h0, s_ready}, 32'h0);
        chk("rst_core_reset", {31'h0, core_reset}, 32'h1);
        chk("rst_load_done", {31'h0, load_done}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic read_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        instr_addr = addr;
        #1;
        chk(tag, instr_out, exp);
    endtask

    task automatic valid_pulses(input logic [7:0] b, input int n);
        s_valid = 1'b1;
        s_data  = b;
        repeat (n) @(negedge clk);
        s_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset_n     = 1'b0;
        s_valid     = 1'b0;
        s_data      = 8'h00;
        instr_addr  = 32'h0;
        instr_addr2 = 32'h0040_0000;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("reset_s_ready", {31'h0, s_ready}, 32'h0);
        chk("reset_core_reset", {31'h0, core_reset}, 32'h1);
        chk("reset_load_done", {31'h0, load_done}, 32'h0);
        chk("reset_load_error", {31'h0, load_error}, 32'h0);
        chk("reset_words", {16'h0, words_loaded}, 32'h0);
        chk("reset_instr", instr_out, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("ready_after_release", {31'h0, s_ready}, 32'h1);

        // Basic load
        send(8'h02, 0); send(8'h00, 0);
        send(8'h78, 0); send(8'h56, 0); send(8'h34, 0); send(8'h12, 0);
        chk("basic_words_1", {16'h0, words_loaded}, 32'h1);
        send(8'hEF, 0); send(8'hBE, 0); send(8'hAD, 0);
        chk("basic_core_reset_before_last", {31'h0, core_reset}, 32'h1);
        chk("basic_instr_before_run", instr_out, 32'h0);
        send(8'hDE, 0);
        chk("basic_core_reset_after", {31'h0, core_reset}, 32'h0);
        chk("basic_load_done", {31'h0, load_done}, 32'h1);
        chk("basic_s_ready_run", {31'h0, s_ready}, 32'h0);
        chk("basic_words_2", {16'h0, words_loaded}, 32'h2);
        read_chk("basic_mem0", 32'h0, 32'h1234_5678);
        read_chk("basic_mem1", 32'h4, 32'hDEAD_BEEF);
        read_chk("basic_past_len", 32'h8, 32'h0);
        read_chk("mask_misaligned", 32'h2, 32'h0);
        instr_addr2 = 32'h0040_0004;
        #1;
        chk("hi_base_mem1", instr_out2, 32'hDEAD_BEEF);
        instr_addr2 = 32'h003F_FFFC;
        #1;
        chk("hi_below_base", instr_out2, 32'h0);

        // s_valid in RUN changes nothing
        valid_pulses(8'hFF, 3);
        chk("run_pulse_words", {16'h0, words_loaded}, 32'h2);
        chk("run_pulse_done", {31'h0, load_done}, 32'h1);
        read_chk("run_pulse_mem0", 32'h0, 32'h1234_5678);

        // Zero length
        pulse_reset();
        send(8'h00, 0); send(8'h00, 0);
        chk("zero_load_error", {31'h0, load_error}, 32'h1);
        chk("zero_s_ready", {31'h0, s_ready}, 32'h0);
        chk("zero_core_reset", {31'h0, core_reset}, 32'h1);
        valid_pulses(8'h02, 4);
        chk("zero_words_after_pulses", {16'h0, words_loaded}, 32'h0);
        chk("zero_error_sticky", {31'h0, load_error}, 32'h1);
        read_chk("zero_instr_masked", 32'h0, 32'h0);

        // Oversize length (DEPTH_WORDS + 1 = 17)
        pulse_reset();
        chk("over_error_cleared", {31'h0, load_error}, 32'h0);
        send(8'h11, 0); send(8'h00, 0);
        chk("over_load_error", {31'h0, load_error}, 32'h1);
        chk("over_s_ready", {31'h0, s_ready}, 32'h0);
        chk("over_core_reset", {31'h0, core_reset}, 32'h1);
        chk("over_load_done", {31'h0, load_done}, 32'h0);

        // Basic stream with random idle gaps
        pulse_reset();
        send(8'h02, 3); send(8'h00, 3);
        send(8'h78, 3); send(8'h56, 3); send(8'h34, 3); send(8'h12, 3);
        send(8'hEF, 3); send(8'hBE, 3); send(8'hAD, 3); send(8'hDE, 3);
        chk("gap_words", {16'h0, words_loaded}, 32'h2);
        chk("gap_core_reset", {31'h0, core_reset}, 32'h0);
        read_chk("gap_mem0", 32'h0, 32'h1234_5678);
        read_chk("gap_mem1", 32'h4, 32'hDEAD_BEEF);

        // Reset after 5 accepted bytes, then reload a one-word image
        pulse_reset();
        send(8'h02, 0); send(8'h00, 0); send(8'h78, 0); send(8'h56, 0); send(8'h34, 0);
        pulse_reset();
        chk("mid_words", {16'h0, words_loaded}, 32'h0);
        chk("mid_core_reset", {31'h0, core_reset}, 32'h1);
        chk("mid_s_ready", {31'h0, s_ready}, 32'h1);
        read_chk("mid_instr", 32'h0, 32'h0);
        send(8'h01, 0); send(8'h00, 0);
        send(8'h09, 0); send(8'h00, 0); send(8'h1D, 0); send(8'h24, 0);
        chk("reload_done", {31'h0, load_done}, 32'h1);
        chk("reload_words", {16'h0, words_loaded}, 32'h1);
        read_chk("reload_mem0", 32'h0, 32'h241D_0009);
        read_chk("reload_old_word_masked", 32'h4, 32'h0);
        instr_addr2 = 32'h0040_0000;
        #1;
        chk("reload_hi_base_mem0", instr_out2, 32'h241D_0009);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
